// File: rtl/wf_ctrl_mc.sv
// ---------------------------------------------------------------------------
// wf_ctrl_mc -- multi-channel waveform controller
//
// Loads waveform samples from the register side into per-channel XINTF
// dual-port BRAMs and tracks how many samples each channel holds. Each
// channel runs its own IDLE/RUN/RESTART/DONE sequencer. The sequencer drives
// the WF-mode flag to the DSP and watches the DSP's samples-consumed counter
// to detect the end of the waveform.
//
// Optional feature macro: WF_LOOP_EN
//   defined   : loop replay (RESTART state) and o_wf_loop_cnt are present
//   undefined : i_wf_loop is ignored, end of waveform always goes to DONE,
//               and o_wf_loop_cnt reads 0
//
// Ports (channel c occupies bits [c*W +: W] of every per-channel bus):
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_wf_write_*            one-cycle sample write (channel, address, data)
//   i_wf_clear/start/stop   per-channel control pulses
//   i_wf_loop               per-channel loop-mode level
//   i_wf_read_cnt           DSP samples-consumed counter per channel
//   o_xintf_wf_ram_*        per-channel BRAM write port (we mirrors ce)
//   o_dsp_wf_mode           WF mode flag to the DSP
//   o_wf_read_data_num      loaded sample count per channel
//   o_wf_done               one-cycle end-of-waveform pulse
//   o_wf_wr_err             sticky: a write was dropped while running
//   o_wf_loop_cnt           completed loop passes, saturating
// ---------------------------------------------------------------------------
module wf_ctrl_mc #(
  parameter int CH_NUM     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32,
  parameter int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wf_write_en,
  input  logic [CH_W-1:0]              i_wf_write_ch,
  input  logic [ADDR_WIDTH-1:0]        i_wf_write_addr,
  input  logic [DATA_WIDTH-1:0]        i_wf_write_data,
  input  logic [CH_NUM-1:0]            i_wf_clear,
  input  logic [CH_NUM-1:0]            i_wf_start,
  input  logic [CH_NUM-1:0]            i_wf_stop,
  input  logic [CH_NUM-1:0]            i_wf_loop,
  input  logic [CH_NUM*CNT_WIDTH-1:0]  i_wf_read_cnt,
  output logic [CH_NUM*ADDR_WIDTH-1:0] o_xintf_wf_ram_addr,
  output logic [CH_NUM*DATA_WIDTH-1:0] o_xintf_wf_ram_din,
  output logic [CH_NUM-1:0]            o_xintf_wf_ram_ce,
  output logic [CH_NUM-1:0]            o_xintf_wf_ram_we,
  output logic [CH_NUM-1:0]            o_dsp_wf_mode,
  output logic [CH_NUM*CNT_WIDTH-1:0]  o_wf_read_data_num,
  output logic [CH_NUM-1:0]            o_wf_done,
  output logic [CH_NUM-1:0]            o_wf_wr_err,
  output logic [CH_NUM*16-1:0]         o_wf_loop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RESTART = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

`ifndef WF_LOOP_EN
  // Loop level has no effect in this build.
  logic unused_loop_s;
  assign unused_loop_s = ^i_wf_loop;
`endif

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    state_e                  state_q;
    logic                    mode_q;
    logic                    done_q;
    logic                    ce_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   din_q;
    logic [CNT_WIDTH-1:0]    data_num_q;
    logic                    wr_err_q;

    logic [CNT_WIDTH-1:0]    rd_cnt_s;
    logic [CNT_WIDTH-1:0]    addr_p1_s;
    logic                    wr_hit_s;
    logic                    idle_s;
    logic                    go_run_s;
    logic                    end_hit_s;

    // A write to a channel number >= CH_NUM matches no channel here, so it
    // is dropped silently without touching any error flag.
    assign wr_hit_s  = i_wf_write_en && (i_wf_write_ch == CH_W'(c));
    assign rd_cnt_s  = i_wf_read_cnt[c*CNT_WIDTH +: CNT_WIDTH];
    assign addr_p1_s = CNT_WIDTH'(i_wf_write_addr) + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign idle_s    = (state_q == ST_IDLE);
    assign go_run_s  = idle_s && i_wf_start[c] && !i_wf_stop[c] &&
                       (data_num_q != {CNT_WIDTH{1'b0}});
    assign end_hit_s = (state_q == ST_RUN) && !i_wf_stop[c] && (rd_cnt_s >= data_num_q);

    // Sample load path: BRAM port strobe, loaded-sample count and error flag.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        ce_q       <= 1'b0;
        addr_q     <= {ADDR_WIDTH{1'b0}};
        din_q      <= {DATA_WIDTH{1'b0}};
        data_num_q <= {CNT_WIDTH{1'b0}};
        wr_err_q   <= 1'b0;
      end else begin
        ce_q <= 1'b0;
        if (wr_hit_s && idle_s) begin
          ce_q   <= 1'b1;
          addr_q <= i_wf_write_addr;
          din_q  <= i_wf_write_data;
          // A simultaneous clear restarts the count from this write.
          if (i_wf_clear[c] || (addr_p1_s > data_num_q)) begin
            data_num_q <= addr_p1_s;
          end
        end else if (i_wf_clear[c] && idle_s) begin
          data_num_q <= {CNT_WIDTH{1'b0}};
        end
        if (i_wf_clear[c] && idle_s) begin
          wr_err_q <= 1'b0;
        end else if (wr_hit_s && !idle_s) begin
          wr_err_q <= 1'b1;
        end
      end
    end

    // Channel sequencer with registered mode and done outputs.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q <= ST_IDLE;
        mode_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (go_run_s) begin
              state_q <= ST_RUN;
              mode_q  <= 1'b1;
            end else begin
              mode_q  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (i_wf_stop[c]) begin
              state_q <= ST_IDLE;
              mode_q  <= 1'b0;
            end else if (end_hit_s) begin
              mode_q  <= 1'b0;
`ifdef WF_LOOP_EN
              if (i_wf_loop[c]) begin
                state_q <= ST_RESTART;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              mode_q  <= 1'b1;
            end
          end
          ST_RESTART: begin
            // Mode stays low until the DSP has rearmed its counter; the
            // rising edge of mode then starts the next pass.
            if (i_wf_stop[c]) begin
              state_q <= ST_IDLE;
              mode_q  <= 1'b0;
            end else if (rd_cnt_s == {CNT_WIDTH{1'b0}}) begin
              state_q <= ST_RUN;
              mode_q  <= 1'b1;
            end else begin
              mode_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
          end
        endcase
      end
    end

`ifdef WF_LOOP_EN
    logic [15:0] loop_cnt_q;

    // Completed-pass counter: zeroed on clear or run entry, saturating.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        loop_cnt_q <= 16'd0;
      end else if (go_run_s || (i_wf_clear[c] && idle_s)) begin
        loop_cnt_q <= 16'd0;
      end else if (end_hit_s && i_wf_loop[c] && (loop_cnt_q != 16'hFFFF)) begin
        loop_cnt_q <= loop_cnt_q + 16'd1;
      end else begin
        loop_cnt_q <= loop_cnt_q;
      end
    end

    assign o_wf_loop_cnt[c*16 +: 16] = loop_cnt_q;
`else
    assign o_wf_loop_cnt[c*16 +: 16] = 16'd0;
`endif

    assign o_xintf_wf_ram_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    assign o_xintf_wf_ram_din[c*DATA_WIDTH +: DATA_WIDTH]  = din_q;
    assign o_xintf_wf_ram_ce[c]                            = ce_q;
    assign o_xintf_wf_ram_we[c]                            = ce_q;
    assign o_dsp_wf_mode[c]                                = mode_q;
    assign o_wf_read_data_num[c*CNT_WIDTH +: CNT_WIDTH]    = data_num_q;
    assign o_wf_done[c]                                    = done_q;
    assign o_wf_wr_err[c]                                  = wr_err_q;
  end

endmodule

// File: tb/tb_wf_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_wf_ctrl_mc -- scoreboard bench for wf_ctrl_mc (CH_NUM=2, default sizes)
// Expected BRAM writes and done pulses are queued by the stimulus; a monitor
// on the falling edge pops and compares whenever ce or done is presented.
// Level outputs (mode, counts, flags) are compared directly after each edge.
// ---------------------------------------------------------------------------
module tb_wf_ctrl_mc;
  localparam int CH  = 2;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [0:0]        wr_ch = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [CH-1:0]     clr = '0, start = '0, stop = '0, loop = '0;
  logic [CH*CW-1:0]  rd_cnt = '0;
  logic [CH*AW-1:0]  ram_addr;
  logic [CH*DW-1:0]  ram_din;
  logic [CH-1:0]     ram_ce, ram_we, mode, done, wr_err;
  logic [CH*CW-1:0]  data_num;
  logic [CH*16-1:0]  loop_cnt;

  wf_ctrl_mc #(.CH_NUM(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_wf_write_en(wr_en), .i_wf_write_ch(wr_ch),
    .i_wf_write_addr(wr_addr), .i_wf_write_data(wr_data), .i_wf_clear(clr),
    .i_wf_start(start), .i_wf_stop(stop), .i_wf_loop(loop), .i_wf_read_cnt(rd_cnt),
    .o_xintf_wf_ram_addr(ram_addr), .o_xintf_wf_ram_din(ram_din),
    .o_xintf_wf_ram_ce(ram_ce), .o_xintf_wf_ram_we(ram_we), .o_dsp_wf_mode(mode),
    .o_wf_read_data_num(data_num), .o_wf_done(done), .o_wf_wr_err(wr_err),
    .o_wf_loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [AW-1:0] addr; logic [DW-1:0] din; } wr_t;
  wr_t wr_q[$];
  int  done_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int ch, input int val);
    rd_cnt[ch*CW +: CW] = val;
  endtask

  function automatic logic [CW-1:0] dnum(input int ch);
    return data_num[ch*CW +: CW];
  endfunction

  // Issue a write strobe; when it should land, queue the expected BRAM access.
  task automatic wr(input int ch, input int addr, input int data, input bit expect_ce);
    wr_en = 1'b1; wr_ch = ch[0:0]; wr_addr = addr[AW-1:0]; wr_data = data[DW-1:0];
    if (expect_ce) wr_q.push_back('{ch, addr[AW-1:0], data[DW-1:0]});
  endtask

  // Monitor: every ce or done presented must match the head of its queue.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (ram_ce[c] === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_ce", 64'(c), 64'hFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("ce_channel", 64'(c), 64'(e.ch));
          chk("ram_addr", 64'(ram_addr[c*AW +: AW]), 64'(e.addr));
          chk("ram_din", 64'(ram_din[c*DW +: DW]), 64'(e.din));
          chk("ram_we", 64'(ram_we[c]), 64'd1);
        end
      end
      if (done[c] === 1'b1) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'(c), 64'hFF);
        else chk("done_channel", 64'(c), 64'(done_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) tick();
    chk("reset_outputs", 64'({ram_ce, ram_we, mode, done, wr_err}), 64'd0);
    chk("reset_counts", 64'(data_num | 64'(loop_cnt)), 64'd0);
    rst = 1'b0;
    tick();

    // Load ch0 with 100 samples, data = address.
    for (int i = 0; i < 100; i++) begin
      wr(0, i, i, 1'b1);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("ce_idle_after_writes", 64'(ram_ce), 64'd0);
    chk("dnum_ch0_100", 64'(dnum(0)), 64'd100);
    chk("dnum_ch1_0", 64'(dnum(1)), 64'd0);

    // ch1: highest address defines the count; a lower address keeps it.
    wr(1, 19, 16'hABCD, 1'b1); tick();
    wr(1, 5, 16'h0505, 1'b1);  tick();
    wr_en = 1'b0; tick();
    chk("dnum_ch1_max", 64'(dnum(1)), 64'd20);

    // Run ch0 to completion.
    set_rd(0, 0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("mode_ch0_after_start", 64'(mode), 64'b01);
    for (int r = 1; r < 100; r++) begin
      set_rd(0, r);
      tick();
    end
    chk("mode_ch0_at_99", 64'(mode[0]), 64'd1);
    set_rd(0, 100);
    done_q.push_back(0);
    tick();
    chk("mode_ch0_end", 64'(mode[0]), 64'd0);
    tick();
    chk("mode_ch0_idle", 64'(mode[0]), 64'd0);

    // Writes and clears on a running channel are rejected.
    set_rd(1, 0);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    chk("mode_ch1_run", 64'(mode[1]), 64'd1);
    wr(1, 3, 16'h0333, 1'b0); tick(); wr_en = 1'b0;
    chk("wr_err_ch1_set", 64'(wr_err), 64'b10);
    chk("dnum_ch1_kept", 64'(dnum(1)), 64'd20);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    chk("clear_ignored_run", 64'({wr_err[1], dnum(1)}), {31'd0, 1'b1, 32'd20});
    set_rd(1, 20);
    done_q.push_back(1);
    tick(); tick();
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    chk("clear_err_ch1", 64'(wr_err[1]), 64'd0);
    chk("clear_dnum_ch1", 64'(dnum(1)), 64'd0);

    // Start with no samples loaded is ignored.
    set_rd(1, 0);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    chk("start_empty_mode", 64'(mode[1]), 64'd0);
    tick();
    chk("start_empty_idle", 64'(mode[1]), 64'd0);

    // Clear and write together: count restarts from the write -> 10.
    clr[0] = 1'b1; wr(0, 9, 16'h1234, 1'b1); tick();
    clr[0] = 1'b0; wr_en = 1'b0;
    chk("clear_write_dnum", 64'(dnum(0)), 64'd10);
    // Start and stop together: stop wins.
    set_rd(0, 0);
    start[0] = 1'b1; stop[0] = 1'b1; tick();
    start[0] = 1'b0; stop[0] = 1'b0;
    chk("start_stop_mode", 64'(mode[0]), 64'd0);
    tick();
    chk("start_stop_idle", 64'(mode[0]), 64'd0);

    // Reload ch0 to 8 samples.
    clr[0] = 1'b1; wr(0, 7, 16'h0707, 1'b1); tick();
    clr[0] = 1'b0; wr_en = 1'b0;
    chk("dnum_ch0_8", 64'(dnum(0)), 64'd8);

`ifdef WF_LOOP_EN
    loop[0] = 1'b1;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("loop_mode_on", 64'(mode[0]), 64'd1);
    chk("loop_cnt_zero", 64'(loop_cnt[15:0]), 64'd0);
    for (int p = 1; p <= 3; p++) begin
      set_rd(0, 8); tick();
      chk("loop_restart_mode", 64'(mode[0]), 64'd0);
      chk("loop_cnt_pass", 64'(loop_cnt[15:0]), 64'(p));
      set_rd(0, 0); tick();
      chk("loop_rearm_mode", 64'(mode[0]), 64'd1);
    end
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;
    chk("loop_stop_mode", 64'(mode[0]), 64'd0);
    chk("loop_cnt_final", 64'(loop_cnt[15:0]), 64'd3);
    tick();
    chk("loop_stop_idle", 64'(mode[0]), 64'd0);
    loop[0] = 1'b0;
`else
    // Loop level has no effect: end of waveform always finishes.
    loop[0] = 1'b1;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("noloop_mode_on", 64'(mode[0]), 64'd1);
    set_rd(0, 8);
    done_q.push_back(0);
    tick();
    chk("noloop_end_mode", 64'(mode[0]), 64'd0);
    chk("noloop_loop_cnt", 64'(loop_cnt), 64'd0);
    tick();
    set_rd(0, 0);
    loop[0] = 1'b0;
`endif

    // Reset while both channels run.
    wr(1, 4, 16'h0444, 1'b1); tick(); wr_en = 1'b0;
    chk("dnum_ch1_5", 64'(dnum(1)), 64'd5);
    set_rd(0, 0); set_rd(1, 0);
    start = 2'b11; tick(); start = 2'b00;
    chk("both_running", 64'(mode), 64'b11);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_run_flags", 64'({ram_ce, mode, done, wr_err}), 64'd0);
    chk("rst_mid_run_counts", 64'(data_num | 64'(loop_cnt)), 64'd0);

    // Reload and run again after reset.
    wr(0, 2, 16'h0222, 1'b1); tick(); wr_en = 1'b0;
    chk("reload_dnum", 64'(dnum(0)), 64'd3);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("rerun_mode", 64'(mode[0]), 64'd1);
    set_rd(0, 3);
    done_q.push_back(0);
    tick();
    chk("rerun_end_mode", 64'(mode[0]), 64'd0);
    repeat (3) tick();

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
